// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the byte-wide RAM/IO bus between the instruction
// fetch and data memory requesters, serialising 1/2/4-byte accesses into
// byte cycles and assembling read data little-endian.
module ram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 2,
  parameter logic [1:0]  IO_SEL       = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_rd_req,
  input  logic        mem_wr_req,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_len,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic [1:0]  busy,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  input  logic        io_buffer_full
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t        state, state_nx;
  logic          serve_if;
  logic [31:0]   base_q;
  logic [2:0]    len_q;
  logic [2:0]    idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   data_q;
  logic          io_q;
  logic [SW-1:0] starve_q;
  logic [31:0]   ram_a_q;
  logic [1:0]    busy_q;

  logic          grant_if, grant_mem, wr_go, abort, mem_any, if_wins;
  logic [2:0]    len_dec;
  logic [1:0]    rd_lane;

  // Next-state, grant decision and byte-issue qualification
  always_comb begin
    state_nx  = state;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    abort     = 1'b0;
    mem_any   = mem_wr_req | mem_rd_req;
    if_wins   = if_req & ~if_flush & (~mem_any | (starve_q == SW'(STARVE_LIMIT)));
    wr_go     = (state == WR) & rdy_in & ~(io_q & io_buffer_full);
    len_dec   = (mem_len == 3'd1) ? 3'd1 : ((mem_len == 3'd2) ? 3'd2 : 3'd4);
    rd_lane   = idx_q[1:0] - 2'd1;
    if (rdy_in) begin
      unique case (state)
        IDLE: begin
          if (if_wins) begin
            grant_if = 1'b1;
            state_nx = RD;
          end else if (mem_any) begin
            grant_mem = 1'b1;
            state_nx  = mem_wr_req ? WR : RD;
          end
        end
        RD: begin
          if (serve_if && if_flush) begin
            abort    = 1'b1;
            state_nx = IDLE;
          end else if (idx_q == len_q) begin
            state_nx = DONE;
          end
        end
        WR:   if (wr_go && (idx_q + 3'd1 == len_q)) state_nx = DONE;
        DONE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     state <= IDLE;
    else if (rdy_in) state <= state_nx;
  end

  // Access latching, byte sequencing, read assembly and starvation tracking
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      serve_if <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      io_q     <= 1'b0;
      starve_q <= '0;
      ram_a_q  <= '0;
      busy_q   <= '0;
    end else if (rdy_in) begin
      if (!if_req) starve_q <= '0;
      if (grant_if) begin
        serve_if <= 1'b1;
        base_q   <= if_addr;
        len_q    <= 3'd4;
        wdata_q  <= '0;
        io_q     <= 1'b0;
        starve_q <= '0;
        ram_a_q  <= if_addr;
        idx_q    <= '0;
        data_q   <= '0;
      end
      if (grant_mem) begin
        serve_if <= 1'b0;
        base_q   <= mem_addr;
        len_q    <= len_dec;
        wdata_q  <= mem_wdata;
        io_q     <= mem_wr_req & (mem_addr[17:16] == IO_SEL);
        ram_a_q  <= mem_addr;
        idx_q    <= '0;
        data_q   <= '0;
        if (if_req && (starve_q != SW'(STARVE_LIMIT))) starve_q <= starve_q + SW'(1);
      end
      // Reads run one cycle behind the address: idx 0 only presents, each
      // later cycle samples the byte addressed in the previous one.
      if (state == RD && !abort) begin
        if (idx_q != 3'd0) data_q[{rd_lane, 3'b000} +: 8] <= ram_din;
        idx_q <= idx_q + 3'd1;
        if (idx_q + 3'd1 < len_q) ram_a_q <= base_q + {29'd0, idx_q} + 32'd1;
      end
      if (abort) data_q <= '0;
      if (wr_go) begin
        idx_q   <= idx_q + 3'd1;
        ram_a_q <= base_q + {29'd0, idx_q} + 32'd1;
      end
      if (state_nx == IDLE || state_nx == DONE) ram_a_q <= '0;
      if (state_nx == IDLE)  busy_q <= '0;
      else if (grant_if)     busy_q <= 2'b10;
      else if (grant_mem)    busy_q <= 2'b01;
    end
  end

  assign ram_wr    = wr_go;
  assign ram_dout  = (state == WR) ? wdata_q[{idx_q[1:0], 3'b000} +: 8] : 8'h00;
  assign ram_a     = ram_a_q;
  assign busy      = busy_q;
  assign if_done   = (state == DONE) & serve_if & rdy_in;
  assign mem_done  = (state == DONE) & ~serve_if & rdy_in;
  assign if_data   = data_q;
  assign mem_rdata = data_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed scenarios with a transaction-level
// reference model compared against the DUT every cycle.
module tb_ram_port_arbiter;
  localparam int LIM = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_rd_req = 1'b0;
  logic        mem_wr_req = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [2:0]  mem_len = '0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [1:0]  busy;
  logic [7:0]  ram_din = '0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_buffer_full = 1'b0;

  ram_port_arbiter #(.STARVE_LIMIT(LIM), .IO_SEL(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .busy(busy),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  ram_mem [0:65535];
  logic [31:0] ram_a_prev = '0;

  // model state: phase 0 idle, 1 transferring, 2 done
  int          m_phase = 0;
  bit          m_if, m_wr, m_io;
  logic [31:0] m_base, m_wdata, m_data;
  int          m_n, m_k;
  int          m_starve = 0;

  logic [1:0]  prev_busy = '0;
  int          dut_wr_cnt = 0;
  int          dut_grants[$];
  int          exp_grants[6] = '{2, 2, 1, 2, 2, 1};

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic m_start(input bit is_if, input bit wr, input logic [31:0] a,
                         input int n, input logic [31:0] wd);
    logic [31:0] ba;
    m_phase = 1; m_k = 0; m_if = is_if; m_wr = wr; m_base = a; m_n = n;
    m_wdata = wd; m_io = wr && (a[17:16] == 2'b11); m_data = '0;
    if (!wr)
      for (int i = 0; i < n; i++) begin
        ba = a + i;
        m_data[8*i +: 8] = ram_mem[ba[15:0]];
      end
  endtask

  task automatic model_step();
    logic [1:0] eb;
    bit ewr, mem_any, if_ok;
    int n;
    if (!rst_in) begin
      m_phase = 0; m_starve = 0; m_k = 0; prev_busy = '0;
      check32("rst_ram_a", ram_a, 32'h0);
      check32("rst_ctl", {22'd0, busy, if_done, mem_done, ram_wr, ram_dout}, 32'h0);
      check32("rst_if_data", if_data, 32'h0);
      check32("rst_mem_rdata", mem_rdata, 32'h0);
      return;
    end
    eb = (m_phase == 0) ? 2'b00 : (m_if ? 2'b10 : 2'b01);
    check32("busy", busy, eb);
    check32("if_done", if_done, m_phase == 2 && m_if && rdy_in);
    check32("mem_done", mem_done, m_phase == 2 && !m_if && rdy_in);
    if (m_phase == 2 && rdy_in && !m_wr) begin
      if (m_if) check32("if_data", if_data, m_data);
      else      check32("mem_rdata", mem_rdata, m_data);
    end
    ewr = m_phase == 1 && m_wr && rdy_in && !(m_io && io_buffer_full);
    check32("ram_wr", ram_wr, ewr);
    if (m_phase != 1) check32("ram_a_idle", ram_a, 32'h0);
    else if (m_wr || m_k < m_n) check32("ram_a", ram_a, m_base + m_k);
    if (ewr) check32("ram_dout", ram_dout, m_wdata[8*m_k +: 8]);

    if (ram_wr) dut_wr_cnt++;
    if (prev_busy == 2'b00 && busy != 2'b00) dut_grants.push_back(busy == 2'b10 ? 1 : 2);
    prev_busy = busy;

    if (rdy_in) begin
      if (!if_req) m_starve = 0;
      case (m_phase)
        0: begin
          mem_any = mem_wr_req || mem_rd_req;
          if_ok = if_req && !if_flush;
          if (if_ok && (!mem_any || m_starve == LIM)) begin
            m_start(1, 0, if_addr, 4, '0);
            m_starve = 0;
          end else if (mem_any) begin
            n = (mem_len == 3'd1) ? 1 : ((mem_len == 3'd2) ? 2 : 4);
            m_start(0, mem_wr_req, mem_addr, n, mem_wdata);
            if (if_req && m_starve < LIM) m_starve++;
          end
        end
        1: begin
          if (!m_wr) begin
            if (m_if && if_flush) m_phase = 0;
            else if (m_k == m_n) m_phase = 2;
            else m_k++;
          end else if (ewr) begin
            m_k++;
            if (m_k == m_n) m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
      // RAM: writes land at end of cycle, reads return the previous cycle's address
      if (ram_wr) ram_mem[ram_a[15:0]] = ram_dout;
      ram_din = ram_mem[ram_a_prev[15:0]];
      ram_a_prev = ram_a;
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_done(input bit want_if, output int n, output logic [31:0] d);
    bit found;
    found = 0; n = 0; d = '0;
    while (!found && n < 40) begin
      @(negedge clk_in);
      n++;
      if (want_if ? if_done : mem_done) begin
        found = 1;
        d = want_if ? if_data : mem_rdata;
      end
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done pulse in 40 cycles, expected one");
    end
    tick();
  endtask

  task automatic mem_op(input bit wr, input logic [31:0] a, input logic [2:0] len,
                        input logic [31:0] wd, output int n, output logic [31:0] d);
    mem_addr = a; mem_len = len; mem_wdata = wd;
    mem_wr_req = wr; mem_rd_req = !wr;
    wait_done(0, n, d);
    mem_wr_req = 0; mem_rd_req = 0;
  endtask

  initial begin
    int n, w0;
    logic [31:0] d;
    for (int i = 0; i < 65536; i++) ram_mem[i] = 8'(i * 7 + 3);
    ram_mem[16'h1000] = 8'h13; ram_mem[16'h1001] = 8'h05;
    ram_mem[16'h1002] = 8'h00; ram_mem[16'h1003] = 8'h00;
    fork
      forever begin
        @(negedge clk_in);
        model_step();
      end
    join_none

    repeat (3) tick();
    check32("reset_busy", busy, 32'h0);
    check32("reset_ram_a", ram_a, 32'h0);
    rst_in = 1;
    tick();

    // IF word fetch
    if_addr = 32'h0000_1000; if_req = 1;
    wait_done(1, n, d);
    if_req = 0;
    check32("if_word", d, 32'h0000_0513);
    check32("if_latency", n, 7);

    // MEM 4-byte write, then reads of 1, 2 and len=3 (4) bytes
    mem_op(1, 32'h0000_0100, 3'd4, 32'hDEAD_BEEF, n, d);
    check32("wr4_latency", n, 6);
    check32("wr4_mem", {ram_mem[16'h103], ram_mem[16'h102], ram_mem[16'h101], ram_mem[16'h100]}, 32'hDEAD_BEEF);
    mem_op(0, 32'h0000_1001, 3'd1, '0, n, d);
    check32("rd1_data", d, 32'h0000_0005);
    check32("rd1_latency", n, 4);
    mem_op(0, 32'h0000_0100, 3'd2, '0, n, d);
    check32("rd2_data", d, 32'h0000_BEEF);
    check32("rd2_latency", n, 5);
    mem_op(0, 32'h0000_0100, 3'd3, '0, n, d);
    check32("rd3as4_data", d, 32'hDEAD_BEEF);

    // 32-bit address wrap
    mem_op(1, 32'hFFFF_FFFE, 3'd4, 32'h1122_3344, n, d);
    mem_op(0, 32'hFFFF_FFFE, 3'd4, '0, n, d);
    check32("wrap_data", d, 32'h1122_3344);
    check32("wrap_low_byte", ram_mem[16'h0001], 32'h11);

    // write wins over read
    mem_addr = 32'h300; mem_len = 3'd1; mem_wdata = 32'h5A;
    mem_wr_req = 1; mem_rd_req = 1;
    wait_done(0, n, d);
    mem_wr_req = 0; mem_rd_req = 0;
    check32("wr_priority", ram_mem[16'h300], 32'h5A);

    // starvation: both requesters held
    dut_grants.delete();
    if_addr = 32'h1000; if_req = 1;
    mem_addr = 32'h100; mem_len = 3'd4; mem_rd_req = 1;
    for (int c = 0; c < 100 && dut_grants.size() < 6; c++) tick();
    if_req = 0; mem_rd_req = 0;
    repeat (12) tick();
    for (int i = 0; i < 6; i++)
      check32($sformatf("grant%0d", i), (i < dut_grants.size()) ? dut_grants[i] : 0, exp_grants[i]);

    // flush in c2 of an IF read with a MEM read pending
    if_addr = 32'h2000; if_req = 1;
    tick();
    mem_addr = 32'h1001; mem_len = 3'd1; mem_rd_req = 1;
    tick();
    tick();
    if_flush = 1; if_req = 0;
    tick();
    if_flush = 0;
    check32("flush_idle_busy", busy, 32'h0);
    tick();
    check32("flush_mem_grant", busy, 32'h1);
    wait_done(0, n, d);
    mem_rd_req = 0;
    check32("flush_mem_latency", n, 3);
    check32("flush_mem_data", d, 32'h5);

    // IO write held while UART buffer full
    w0 = dut_wr_cnt;
    io_buffer_full = 1;
    mem_addr = 32'h0003_0000; mem_len = 3'd1; mem_wdata = 32'h41; mem_wr_req = 1;
    repeat (4) tick();
    io_buffer_full = 0;
    wait_done(0, n, d);
    mem_wr_req = 0;
    check32("io_latency", n, 2);
    check32("io_writes", dut_wr_cnt - w0, 1);
    check32("io_byte", ram_mem[16'h0000], 32'h41);

    // rdy pause in a 2-byte write
    w0 = dut_wr_cnt;
    mem_addr = 32'h200; mem_len = 3'd2; mem_wdata = 32'h0000_A55A; mem_wr_req = 1;
    repeat (2) tick();
    rdy_in = 0;
    repeat (2) tick();
    rdy_in = 1;
    wait_done(0, n, d);
    mem_wr_req = 0;
    check32("rdy_latency", n, 2);
    check32("rdy_writes", dut_wr_cnt - w0, 2);
    check32("rdy_bytes", {ram_mem[16'h201], ram_mem[16'h200]}, 32'hA55A);

    // async reset mid IF read
    if_addr = 32'h1000; if_req = 1;
    repeat (3) tick();
    #2 rst_in = 0;
    #1;
    check32("async_rst_ram_a", ram_a, 32'h0);
    check32("async_rst_busy", busy, 32'h0);
    check32("async_rst_if_data", if_data, 32'h0);
    if_req = 0;
    repeat (2) tick();
    rst_in = 1;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single byte-wide RAM/IO bus between the instruction-fetch requester and the data-memory requester.
- Serialises each 1/2/4-byte access into byte cycles, assembles read data little-endian, and holds IO-space writes while the UART buffer is full.
- Sits between the IF/MEM stages and the top-level mem_a/mem_dout/mem_din/mem_wr pins.

Parameters:
STARVE_LIMIT, 2, maximum consecutive MEM grants while if_req is pending before IF is forced next.
IO_SEL, 2'b11, value of address bits [17:16] that selects IO space.

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global ready; low freezes the block
if_req  in  1  IF requests a 4-byte read
if_addr  in  32  IF byte address
if_flush  in  1  abort any pending or in-flight IF access
if_done  out  1  one-cycle pulse; if_data valid
if_data  out  32  fetched word
mem_rd_req  in  1  MEM read request
mem_wr_req  in  1  MEM write request
mem_addr  in  32  MEM byte address
mem_wdata  in  32  MEM write data, byte i = bits [8i+7:8i]
mem_len  in  3  access bytes: 1, 2, else 4
mem_done  out  1  one-cycle pulse; access complete, mem_rdata valid for reads
mem_rdata  out  32  read data, zero-extended
busy  out  2  [1] serving IF, [0] serving MEM
ram_din  in  8  RAM/IO read byte (valid one cycle after address)
ram_dout  out  8  write byte
ram_a  out  32  byte address
ram_wr  out  1  1 = write
io_buffer_full  in  1  UART TX buffer full

Behaviour:
- Reset (rst_in=0, any time, async): state IDLE; all outputs 0; byte counter, starve counter and data registers 0. Any in-flight access is discarded with no done pulse.
- rdy_in=0: all registers hold; ram_wr forced 0 combinationally; done pulses are not issued.
- States: IDLE, RD, WR, DONE.
- Requester protocol:
  - Requester holds req, addr, len and wdata stable until it sees done.
  - Arbiter latches addr, len and wdata at grant.
  - Requester drops req in the done cycle.
  - No grant is made from DONE (prevents stale re-grant).
- Grant in IDLE:
  - mem_wr_req beats mem_rd_req when both are high.
  - MEM beats IF, except IF wins when starve_cnt==STARVE_LIMIT.
  - starve_cnt increments on a MEM grant with if_req high; it clears on an IF grant or when if_req is low.
  - IF is not granted while if_flush=1.
- Addresses: registered outputs; ram_a = base + byte_idx. In IDLE and DONE, ram_a=0 and ram_wr=0.
- RD, N bytes:
  - Address bytes 0..N-1 are presented in consecutive cycles c0..c(N-1).
  - ram_din for byte i is sampled at the end of cycle c(i+1).
  - DONE is entered after the last sample; done and data are valid in cycle c(N+1).
  - 4-byte read: grant edge to done = N+2 edges.
- WR, N bytes:
  - ram_wr=1, ram_a=base+i, ram_dout=byte i in cycle ci.
  - DONE follows cycle c(N-1); 4-byte write: done in c4.
- IO hold: for a write with base[17:16]==IO_SEL, a byte cycle issues only if io_buffer_full=0. Otherwise the cycle is idle (ram_wr=0, byte_idx held) and is retried the next cycle.
- if_flush=1 while serving IF: go to IDLE at the next edge, no if_done, partial data discarded. MEM accesses are never aborted.
- DONE lasts one cycle, then IDLE. busy bit is set from grant through DONE inclusive.
- Address arithmetic is 32-bit wrap-around; no alignment checking.

Test Plan:
- IF read 0x00001000, RAM bytes 13,05,00,00 -> ram_a 0x1000..0x1003 in c0..c3; if_done in c5 with if_data=0x00000513; busy=2'b10 during c0..c5.
- MEM 4-byte write 0x00000100 data 0xDEADBEEF -> ram_wr=1 c0..c3 with dout EF,BE,AD,DE at 0x100..0x103; mem_done in c4.
- if_req and mem_rd_req held continuously, STARVE_LIMIT=2 -> grant order MEM, MEM, IF, MEM, MEM, IF.
- MEM 1-byte write 0x00030000 data 0x41, io_buffer_full=1 for 3 cycles -> ram_wr stays 0 for 3 cycles, then one write of 0x41; mem_done the following cycle.
- if_flush pulsed in c2 of an IF read -> no if_done; IDLE next cycle; a pending mem_rd_req is granted immediately after.
- rdy_in low for 2 cycles mid 2-byte write -> ram_wr=0 during the pause, no duplicate byte; rst_in low mid-read -> all outputs 0 asynchronously, no done pulse.
